// File: rtl/fir_host_pkg.sv
// -----------------------------------------------------------------------------
// fir_host_pkg
// Shared constants and types for the host side of the FIR-over-UART link.
//   SAMPLE_W / BYTES_PER_SAMPLE : 16-bit samples, sent as 2 bytes, LSB first
//   RESULT_W / BYTES_PER_RESULT : 38-bit results, received as 5 bytes, LSB first
//   DEFAULT_TIMEOUT_CYCLES      : inter-byte idle limit used when the
//                                 FIR_HOST_TIMEOUT_EN macro is defined
//   tx_state_t                  : transmit FSM encoding (visible as r_tx_state
//                                 inside fir_uart_host)
// -----------------------------------------------------------------------------
package fir_host_pkg;

   localparam int SAMPLE_W               = 16;
   localparam int RESULT_W               = 38;
   localparam int BYTES_PER_SAMPLE       = 2;
   localparam int BYTES_PER_RESULT       = 5;
   localparam int DEFAULT_TIMEOUT_CYCLES = 100000;

   typedef enum logic [2:0] {
      TX_IDLE     = 3'd0,
      TX_LO_START = 3'd1,
      TX_LO_WAIT  = 3'd2,
      TX_HI_START = 3'd3,
      TX_HI_WAIT  = 3'd4
   } tx_state_t;

   // Byte 0 is the low byte; byte 1 the high byte.
   function automatic logic [7:0] sample_byte(input logic [SAMPLE_W-1:0] s,
                                              input logic                hi);
      return hi ? s[15:8] : s[7:0];
   endfunction

endpackage

// File: rtl/fir_host_rx_assembler.sv
// -----------------------------------------------------------------------------
// fir_host_rx_assembler
// Collects 5 received UART bytes (LSB first) into one 38-bit FIR result.
// The top 2 bits of the last byte fall outside the result and are dropped.
// Optional macro FIR_HOST_TIMEOUT_EN: a partial result that sees no new byte
// for TIMEOUT_CYCLES clocks is dropped and the sticky rx_error flag is set.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   rx_valid        one-cycle strobe, rx_byte valid
//   rx_byte [7:0]   received byte
//   result_valid    one-cycle pulse when result_data has just been updated
//   result_data     assembled result, held until the next one
//   rx_error        sticky timeout flag (constant 0 without the macro)
// -----------------------------------------------------------------------------
module fir_host_rx_assembler
   import fir_host_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                rx_valid,
   input  logic [7:0]          rx_byte,
   output logic                result_valid,
   output logic [RESULT_W-1:0] result_data,
   output logic                rx_error
);

   localparam logic [2:0] LAST_IDX = 3'(BYTES_PER_RESULT - 1);
   localparam int         LOW_W    = (BYTES_PER_RESULT - 1) * 8;

   if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
      $error("fir_host_rx_assembler: TIMEOUT_CYCLES must be at least 2");
   end

   logic [2:0]          r_cnt;
   logic [LOW_W-1:0]    r_shift;
   logic                r_result_valid;
   logic [RESULT_W-1:0] r_result_data;
   logic                w_timeout;

`ifdef FIR_HOST_TIMEOUT_EN
   localparam int              IDLE_W     = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [IDLE_W-1:0] IDLE_LIMIT = IDLE_W'(TIMEOUT_CYCLES - 1);

   logic [IDLE_W-1:0] r_idle;
   logic              r_rx_error;

   // Fires on the TIMEOUT_CYCLES-th idle clock of a partial result.
   assign w_timeout = (r_cnt != 3'd0) && (r_idle == IDLE_LIMIT);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_idle     <= '0;
         r_rx_error <= 1'b0;
      end else begin
         if (rx_valid || (r_cnt == 3'd0) || w_timeout) begin
            r_idle <= '0;
         end else begin
            r_idle <= r_idle + IDLE_W'(1);
         end
         if (w_timeout) begin
            r_rx_error <= 1'b1;
         end
      end
   end

   assign rx_error = r_rx_error;
`else
   assign w_timeout = 1'b0;
   assign rx_error  = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt          <= 3'd0;
         r_shift        <= '0;
         r_result_valid <= 1'b0;
         r_result_data  <= '0;
      end else begin
         r_result_valid <= 1'b0;
         if (w_timeout) begin
            // Partial result is dropped; a byte on this cycle opens a new one.
            r_cnt <= 3'd0;
            if (rx_valid) begin
               r_shift[7:0] <= rx_byte;
               r_cnt        <= 3'd1;
            end
         end else if (rx_valid) begin
            if (r_cnt == LAST_IDX) begin
               r_result_data  <= {rx_byte[RESULT_W-LOW_W-1:0], r_shift};
               r_result_valid <= 1'b1;
               r_cnt          <= 3'd0;
            end else begin
               r_shift[{r_cnt[1:0], 3'b000} +: 8] <= rx_byte;
               r_cnt <= r_cnt + 3'd1;
            end
         end
      end
   end

   assign result_valid = r_result_valid;
   assign result_data  = r_result_data;

endmodule

// File: rtl/fir_uart_host.sv
// -----------------------------------------------------------------------------
// fir_uart_host
// Host-side peer of the FIR-over-UART link. Sends 16-bit samples as two UART
// bytes (LSB first) through a start/busy transmitter handshake and rebuilds
// 38-bit FIR results from 5 received bytes.
// Optional macro FIR_HOST_TIMEOUT_EN enables the receive inter-byte timeout.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   sample_valid/ready/data  sample input; a transfer happens on the clock
//                            where valid and ready are both high; ready is high
//                            only while the transmit FSM is idle
//   TxD_start, TxD_data      one-cycle start pulse and the byte to send; the
//                            byte stays stable until the next start
//   TxD_busy                 transmitter busy
//   RxD_data_ready, RxD_data received byte strobe and byte
//   result_valid, result_data one-cycle result pulse, result held afterwards
//   rx_error                 sticky receive timeout flag
// -----------------------------------------------------------------------------
module fir_uart_host
   import fir_host_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                sample_valid,
   output logic                sample_ready,
   input  logic [SAMPLE_W-1:0] sample_data,
   output logic                TxD_start,
   output logic [7:0]          TxD_data,
   input  logic                TxD_busy,
   input  logic                RxD_data_ready,
   input  logic [7:0]          RxD_data,
   output logic                result_valid,
   output logic [RESULT_W-1:0] result_data,
   output logic                rx_error
);

   if (BYTES_PER_SAMPLE * 8 != SAMPLE_W) begin : g_bad_sample_w
      $error("fir_uart_host: sample width must be BYTES_PER_SAMPLE bytes");
   end

   tx_state_t           r_tx_state;
   logic                r_sample_ready;
   logic                r_txd_start;
   logic [7:0]          r_txd_data;
   logic [SAMPLE_W-1:0] r_sample;
   // High during the start-pulse cycle: the transmitter has not raised busy
   // yet, so busy must not be trusted on that cycle.
   logic                r_skip_busy;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_tx_state     <= TX_IDLE;
         r_sample_ready <= 1'b0;
         r_txd_start    <= 1'b0;
         r_txd_data     <= 8'd0;
         r_sample       <= '0;
         r_skip_busy    <= 1'b0;
      end else begin
         r_txd_start <= 1'b0;
         case (r_tx_state)
            TX_IDLE: begin
               r_sample_ready <= 1'b1;
               if (sample_valid && r_sample_ready) begin
                  r_sample       <= sample_data;
                  r_sample_ready <= 1'b0;
                  r_tx_state     <= TX_LO_START;
               end
            end
            TX_LO_START, TX_HI_START: begin
               if (!TxD_busy) begin
                  r_txd_start <= 1'b1;
                  r_txd_data  <= sample_byte(r_sample, r_tx_state == TX_HI_START);
                  r_skip_busy <= 1'b1;
                  r_tx_state  <= (r_tx_state == TX_HI_START) ? TX_HI_WAIT : TX_LO_WAIT;
               end
            end
            TX_LO_WAIT, TX_HI_WAIT: begin
               if (r_skip_busy) begin
                  r_skip_busy <= 1'b0;
               end else if (!TxD_busy) begin
                  if (r_tx_state == TX_HI_WAIT) begin
                     r_tx_state     <= TX_IDLE;
                     r_sample_ready <= 1'b1;
                  end else begin
                     r_tx_state <= TX_HI_START;
                  end
               end
            end
            default: begin
               r_tx_state     <= TX_IDLE;
               r_sample_ready <= 1'b0;
            end
         endcase
      end
   end

   assign sample_ready = r_sample_ready;
   assign TxD_start    = r_txd_start;
   assign TxD_data     = r_txd_data;

   fir_host_rx_assembler #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_rx (
      .clk          (clk),
      .rst          (rst),
      .rx_valid     (RxD_data_ready),
      .rx_byte      (RxD_data),
      .result_valid (result_valid),
      .result_data  (result_data),
      .rx_error     (rx_error)
   );

endmodule

// File: tb/tb_fir_uart_host.sv
// -----------------------------------------------------------------------------
// tb_fir_uart_host
// Bench for fir_uart_host. A simple UART transmitter model answers the
// start/busy handshake; sample and byte drivers feed a reference model of the
// byte stream and result stream; one monitor compares the DUT every cycle.
// Build with FIR_HOST_TIMEOUT_EN defined to also exercise the timeout.
// -----------------------------------------------------------------------------
module tb_fir_uart_host;

   // ---------------- clock / reset ----------------
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   always #5 clk = ~clk;

   logic        sample_valid = 1'b0;
   logic        sample_ready;
   logic [15:0] sample_data = 16'd0;
   logic        TxD_start;
   logic [7:0]  TxD_data;
   logic        TxD_busy = 1'b0;
   logic        RxD_data_ready = 1'b0;
   logic [7:0]  RxD_data = 8'd0;
   logic        result_valid;
   logic [37:0] result_data;
   logic        rx_error;

   fir_uart_host #(.TIMEOUT_CYCLES(20)) dut (
      .clk            (clk),
      .rst            (rst),
      .sample_valid   (sample_valid),
      .sample_ready   (sample_ready),
      .sample_data    (sample_data),
      .TxD_start      (TxD_start),
      .TxD_data       (TxD_data),
      .TxD_busy       (TxD_busy),
      .RxD_data_ready (RxD_data_ready),
      .RxD_data       (RxD_data),
      .result_valid   (result_valid),
      .result_data    (result_data),
      .rx_error       (rx_error)
   );

   // ---------------- scoreboard state ----------------
   int          checks   = 0;
   int          failures = 0;
   int          cyc      = 0;
   bit          mon_en   = 1'b0;
   logic [7:0]  exp_q[$];          // bytes the transmitter must still see
   logic [7:0]  tx_log[$];         // bytes actually started
   int          lat_q[$];          // expected cycle of each low-byte start (-1 = unknown)
   bit          tx_hi    = 1'b0;
   logic [7:0]  rx_part[$];
   logic [37:0] res_q[$];
   int          due_q[$];
   logic [37:0] last_result = 38'd0;
   int          pulses   = 0;
   int          uart_cnt = 0;
   bit          force_busy = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- UART transmitter model ----------------
   // A byte already started keeps the line busy even across a host reset.
   always @(negedge clk) begin
      if (TxD_start) uart_cnt = $urandom_range(2, 6);
      else if (uart_cnt > 0) uart_cnt--;
      TxD_busy = (uart_cnt > 0) || force_busy;
   end

   // ---------------- reference model of received results ----------------
   function automatic void model_rx(input logic [7:0] b);
      logic [39:0] v;
      rx_part.push_back(b);
      if (rx_part.size() == 5) begin
         v = {rx_part[4], rx_part[3], rx_part[2], rx_part[1], rx_part[0]};
         res_q.push_back(v[37:0]);
         due_q.push_back(cyc + 1);
         rx_part.delete();
      end
   endfunction

   // ---------------- drivers ----------------
   task automatic send_sample(input logic [15:0] d);
      int n = 0;
      @(negedge clk);
      sample_valid = 1'b1;
      sample_data  = d;
      while (!sample_ready && n < 500) begin
         @(negedge clk);
         n++;
      end
      if (!sample_ready) begin
         chk("accept_timeout", 0, 1);
         sample_valid = 1'b0;
         return;
      end
      exp_q.push_back(d[7:0]);
      exp_q.push_back(d[15:8]);
      lat_q.push_back(force_busy ? -1 : cyc + 2);
      @(negedge clk);
      sample_valid = 1'b0;
   endtask

   task automatic rx_byte(input logic [7:0] b);
      @(negedge clk);
      RxD_data_ready = 1'b1;
      RxD_data       = b;
      model_rx(b);
   endtask

   task automatic rx_idle(input int n);
      repeat (n) begin
         @(negedge clk);
         RxD_data_ready = 1'b0;
      end
   endtask

   task automatic wait_tx(input int n);
      int k = 0;
      while (tx_log.size() < n && k < 2000) begin
         @(negedge clk);
         k++;
      end
      if (tx_log.size() < n) chk("tx_wait_timeout", tx_log.size(), n);
   endtask

   task automatic wait_ready();
      int k = 0;
      while (!sample_ready && k < 2000) begin
         @(negedge clk);
         k++;
      end
      chk("ready_return", sample_ready, 1);
   endtask

   task automatic check_reset_outputs();
      chk("rst_sample_ready", sample_ready, 0);
      chk("rst_txd_start", TxD_start, 0);
      chk("rst_txd_data", TxD_data, 0);
      chk("rst_result_valid", result_valid, 0);
      chk("rst_result_data", result_data, 0);
      chk("rst_rx_error", rx_error, 0);
   endtask

   // ---------------- monitor / compare ----------------
   always @(posedge clk) begin
      bit ev;
      int d;
      #1;
      cyc++;
      if (!rst && mon_en) begin
         ev = (due_q.size() > 0) && (due_q[0] == cyc);
         chk("result_valid", result_valid, ev);
         if (ev) begin
            void'(due_q.pop_front());
            last_result = res_q.pop_front();
            pulses++;
         end
         chk("result_data", result_data, last_result);
         if (TxD_start) begin
            chk("start_while_busy", TxD_busy, 0);
            tx_log.push_back(TxD_data);
            if (exp_q.size() == 0) chk("unexpected_start", 1, 0);
            else chk("tx_byte", TxD_data, exp_q.pop_front());
            if (!tx_hi && lat_q.size() > 0) begin
               d = lat_q.pop_front();
               if (d >= 0) chk("start_latency", cyc, d);
            end
            tx_hi = !tx_hi;
         end
         if (sample_ready) begin
            chk("ready_while_pending", exp_q.size(), 0);
            chk("ready_mid_sample", tx_hi, 0);
         end
`ifndef FIR_HOST_TIMEOUT_EN
         chk("rx_error_tied", rx_error, 0);
`endif
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      int n0;
      int p0;

      repeat (3) @(negedge clk);
      check_reset_outputs();
      rst = 1'b0;
      mon_en = 1'b1;
      @(negedge clk);
      chk("ready_after_reset", sample_ready, 1);

      // Single sample, idle UART.
      send_sample(16'hA55A);
      wait_tx(2);
      chk("a55a_byte0", tx_log[0], 8'h5A);
      chk("a55a_byte1", tx_log[1], 8'hA5);
      wait_ready();

      // Single result.
      rx_byte(8'h01); rx_byte(8'h23); rx_byte(8'h45); rx_byte(8'h67); rx_byte(8'hFF);
      rx_idle(3);
      chk("result_literal", result_data, 38'h3F_6745_2301);

      // Transmitter held busy while the FSM waits to start byte 0.
      force_busy = 1'b1;
      repeat (2) @(negedge clk);
      n0 = tx_log.size();
      send_sample(16'hC33C);
      repeat (50) @(negedge clk);
      chk("busy_hold_no_start", tx_log.size(), n0);
      force_busy = 1'b0;
      wait_tx(n0 + 2);
      chk("busy_release_byte0", tx_log[n0], 8'h3C);
      wait_ready();

      // Ten back-to-back results.
      p0 = pulses;
      for (int i = 0; i < 50; i++) rx_byte(8'($urandom));
      rx_idle(3);
      chk("b2b_pulses", pulses - p0, 10);

      // Concurrent random traffic on both paths.
      fork
         begin
            for (int i = 0; i < 15; i++) begin
               send_sample(16'($urandom));
               repeat ($urandom_range(0, 3)) @(negedge clk);
            end
         end
         begin
            for (int i = 0; i < 40; i++) begin
               rx_byte(8'($urandom));
               if ($urandom_range(0, 1) == 1) rx_idle($urandom_range(1, 3));
            end
            rx_idle(3);
         end
      join
      wait_tx(tx_log.size() + exp_q.size());
      wait_ready();
      chk("random_results_drained", res_q.size(), 0);

`ifdef FIR_HOST_TIMEOUT_EN
      // Partial result abandoned by the timeout, then a clean one.
      rx_byte(8'h11); rx_byte(8'h22);
      rx_idle(25);
      chk("timeout_rx_error", rx_error, 1);
      rx_part.delete();
      rx_byte(8'h0A); rx_byte(8'h0B); rx_byte(8'h0C); rx_byte(8'h0D); rx_byte(8'h01);
      rx_idle(3);
      chk("after_timeout_result", result_data, 38'h01_0D0C_0B0A);
      chk("timeout_sticky", rx_error, 1);
`endif

      // Reset in the middle of a sample and of a result.
      rx_byte(8'hEE); rx_byte(8'hDD); rx_byte(8'hCC);
      rx_idle(1);
      n0 = tx_log.size();
      send_sample(16'h5AA5);
      wait_tx(n0 + 2);
      rst = 1'b1;
      mon_en = 1'b0;
      #1;
      check_reset_outputs();
      exp_q.delete(); lat_q.delete(); tx_hi = 1'b0;
      rx_part.delete(); res_q.delete(); due_q.delete();
      last_result = 38'd0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (10) @(negedge clk);
      mon_en = 1'b1;
      n0 = tx_log.size();
      send_sample(16'h9669);
      wait_tx(n0 + 2);
      chk("post_reset_byte0", tx_log[n0], 8'h69);
      chk("post_reset_byte1", tx_log[n0 + 1], 8'h96);
      rx_byte(8'h10); rx_byte(8'h20); rx_byte(8'h30); rx_byte(8'h40); rx_byte(8'hC5);
      rx_idle(3);
      chk("post_reset_result", result_data, 38'h05_4030_2010);
      wait_ready();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Global guard so the run always ends.
   initial begin
      #500000;
      $display("FAIL global_timeout actual=%0d expected=finish", cyc);
      failures++;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "timeout");
   end

endmodule
